// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poll sequencer.
package nes_pkg;

    // Poll sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_DONE
    } nes_state_t;

    // Button bit positions in the buttons vector (pressed = 1)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Default timing at a 900 kHz clock: ~60 Hz polls, 11-cycle latch, 5+5 cycle shift clock
    localparam int NES_POLL_DIV  = 15000;
    localparam int NES_LATCH_CYC = 11;
    localparam int NES_HALF_CYC  = 5;

    // Counter width able to hold 0..max(a,b,c)-1; never narrower than one bit
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nes_poll_timer.sv
// Poll-rate counter: counts 0..POLL_DIV-1 while enabled, strobes wrap on the
// last count, and is held at zero while disabled.
module nes_poll_timer
    import nes_pkg::*;
#(
    parameter int POLL_DIV = NES_POLL_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic wrap
);

    localparam int               CNT_W = cnt_width(POLL_DIV, 1, 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count and wrap strobe; disabling the timer returns it to zero
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            wrap  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/nes_poll_sequencer.sv
// NES controller poll sequencer: latches the pad, clocks out seven more bits,
// and publishes the eight button states atomically with valid/changed strobes.
module nes_poll_sequencer
    import nes_pkg::*;
#(
    parameter int POLL_DIV  = NES_POLL_DIV,
    parameter int LATCH_CYC = NES_LATCH_CYC,
    parameter int HALF_CYC  = NES_HALF_CYC
) (
    input  logic       clk_900KHz,
    input  logic       reset,
    input  logic       poll_en,
    input  logic       poll_req,
    input  logic       data,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       changed,
    output logic       busy
);

    localparam int              PH_W       = cnt_width(LATCH_CYC, HALF_CYC, POLL_DIV);
    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_CYC - 1);

    nes_state_t      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      buttons_q, buttons_d;
    logic            pending_q, pending_d;
    logic            valid_q, valid_d;
    logic            changed_q, changed_d;
    logic            timer_wrap;
    logic            trigger;

    nes_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_poll_timer (
        .clk   (clk_900KHz),
        .reset (reset),
        .en    (poll_en),
        .wrap  (timer_wrap)
    );

    assign trigger = timer_wrap | poll_req;

    // Next-state logic: sequencing, bit capture, and atomic publish on the last sample
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        pending_d = pending_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;

        // Any trigger arriving mid-poll collapses into a single pending poll
        if (state_q != ST_IDLE && state_q != ST_DONE && trigger) pending_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_LATCH;
                    phase_d = '0;
                end
            end
            ST_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    shift_d[0] = ~data;
                    bit_cnt_d  = 3'd1;
                    phase_d    = '0;
                    state_d    = ST_CLK_HI;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_CLK_HI: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    state_d = ST_CLK_LO;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_CLK_LO: begin
                if (phase_q == HALF_LAST) begin
                    shift_d[bit_cnt_q] = ~data;
                    phase_d            = '0;
                    if (bit_cnt_q == 3'd7) begin
                        // Registered so buttons, valid and changed all appear in the DONE cycle
                        state_d   = ST_DONE;
                        buttons_d = shift_d;
                        valid_d   = 1'b1;
                        changed_d = (shift_d != buttons_q);
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = ST_CLK_HI;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                // A trigger landing in DONE itself is treated like a pending one
                if (pending_q || trigger) begin
                    state_d   = ST_LATCH;
                    phase_d   = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any poll in progress
    always_ff @(posedge clk_900KHz) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign latch         = (state_q == ST_LATCH);
    assign pulse         = (state_q == ST_CLK_HI);
    assign busy          = (state_q != ST_IDLE);
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign changed       = changed_q;

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Self-checking bench for nes_poll_sequencer with a shift-register model of
// the NES controller attached to latch/pulse/data.
module tb_nes_poll_sequencer;
    import nes_pkg::*;

    localparam int TB_POLL_DIV = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       poll_en = 1'b0;
    logic       poll_req = 1'b0;
    logic       data;
    logic       latch, pulse, buttons_valid, changed, busy;
    logic [7:0] buttons;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pad = 8'h00;
    int         idx = 8;
    logic       pulse_prev = 1'b0;
    logic [7:0] model_btn;

    typedef struct {
        logic [7:0] pad;
        logic [7:0] exp_btn;
        logic       exp_chg;
    } vec_t;
    vec_t vecs[4];

    nes_poll_sequencer #(
        .POLL_DIV  (TB_POLL_DIV),
        .LATCH_CYC (NES_LATCH_CYC),
        .HALF_CYC  (NES_HALF_CYC)
    ) dut (
        .clk_900KHz    (clk),
        .reset         (reset),
        .poll_en       (poll_en),
        .poll_req      (poll_req),
        .data          (data),
        .latch         (latch),
        .pulse         (pulse),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .changed       (changed),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Controller model: latch reloads, each rising shift clock advances one button
    always @(posedge clk) begin
        pulse_prev <= pulse;
        if (latch) idx <= 0;
        else if (pulse && !pulse_prev && idx < 8) idx <= idx + 1;
    end
    assign data = (idx < 8) ? ~pad[idx[2:0]] : 1'b1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One poll from idle; returns latency of the valid strobe (-1 on timeout)
    task automatic poll_once(input logic [7:0] p, output int lat, output logic [7:0] b, output logic c);
        pad = p;
        lat = -1;
        b = 8'h00;
        c = 1'b0;
        poll_req = 1'b1;
        tick();
        poll_req = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (buttons_valid) begin
                lat = k;
                b = buttons;
                c = changed;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_single();
        int lat_first, lat_last, lat_cnt, pul_first, pul_cnt, pul_rise, overlap;
        int vcnt, vcyc, early_bad, busy_gap;
        logic pp, vchg, busy83;
        logic [7:0] vbtn;
        lat_first = -1; lat_last = -1; lat_cnt = 0; pul_first = -1; pul_cnt = 0;
        pul_rise = 0; overlap = 0; vcnt = 0; vcyc = -1; early_bad = 0; busy_gap = 0;
        pp = 1'b0; vchg = 1'b0; busy83 = 1'b1; vbtn = 8'h00;
        pad = (8'h1 << BTN_A) | (8'h1 << BTN_START);
        poll_req = 1'b1;
        tick();
        poll_req = 1'b0;
        for (int c = 1; c <= 83; c++) begin
            if (latch) begin
                lat_cnt++;
                if (lat_first < 0) lat_first = c;
                lat_last = c;
            end
            if (pulse) begin
                pul_cnt++;
                if (pul_first < 0) pul_first = c;
            end
            if (pulse && !pp) pul_rise++;
            pp = pulse;
            if (latch && pulse) overlap++;
            if (buttons_valid) begin
                vcnt++; vcyc = c; vbtn = buttons; vchg = changed;
            end
            if (c < 82 && buttons !== 8'h00) early_bad++;
            if (c <= 82 && !busy) busy_gap++;
            if (c == 83) busy83 = busy;
            tick();
        end
        check("single_latch_first", lat_first, 1);
        check("single_latch_last", lat_last, 11);
        check("single_latch_cnt", lat_cnt, 11);
        check("single_pulse_first", pul_first, 12);
        check("single_pulse_cycles", pul_cnt, 35);
        check("single_pulse_rises", pul_rise, 7);
        check("single_overlap", overlap, 0);
        check("single_valid_cnt", vcnt, 1);
        check("single_valid_cycle", vcyc, 82);
        check("single_buttons", vbtn, 8'h09);
        check("single_changed", vchg, 1'b1);
        check("single_partial_visible", early_bad, 0);
        check("single_busy_gap", busy_gap, 0);
        check("single_busy_after", busy83, 1'b0);
    endtask

    task automatic test_table();
        int lat;
        logic [7:0] b;
        logic c;
        vecs[0] = '{8'h80, 8'h80, 1'b1};
        vecs[1] = '{8'h10, 8'h10, 1'b1};
        vecs[2] = '{8'h10, 8'h10, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1};
        for (int i = 0; i < 4; i++) begin
            poll_once(vecs[i].pad, lat, b, c);
            check($sformatf("table%0d_latency", i), lat, 82);
            check($sformatf("table%0d_buttons", i), b, vecs[i].exp_btn);
            check($sformatf("table%0d_changed", i), c, vecs[i].exp_chg);
            check($sformatf("table%0d_idle", i), busy, 1'b0);
        end
    endtask

    task automatic test_periodic();
        int rises, first_rise, last_rise, spacing_bad, chg_cnt, vcnt, btn_bad, k_done, late_latch;
        logic lp;
        rises = 0; first_rise = -1; last_rise = -1; spacing_bad = 0;
        chg_cnt = 0; vcnt = 0; btn_bad = 0; k_done = -1; late_latch = 0; lp = 1'b0;
        pad = 8'h00;
        poll_en = 1'b1;
        for (int c = 0; c <= 1000; c++) begin
            if (latch && !lp) begin
                if (first_rise < 0) first_rise = c;
                else if (c - last_rise != TB_POLL_DIV) spacing_bad++;
                last_rise = c;
                rises++;
            end
            lp = latch;
            if (changed) chg_cnt++;
            if (buttons_valid) vcnt++;
            if (buttons !== 8'h00) btn_bad++;
            tick();
        end
        check("periodic_first_start", first_rise, TB_POLL_DIV);
        check("periodic_starts", rises, 5);
        check("periodic_spacing", spacing_bad, 0);
        check("periodic_valid_cnt", vcnt, 4);
        check("periodic_changed", chg_cnt, 0);
        check("periodic_buttons", btn_bad, 0);
        // Disable mid-poll: the running poll must still complete
        poll_en = 1'b0;
        for (int k = 0; k <= 200; k++) begin
            if (buttons_valid) begin
                k_done = k;
                break;
            end
            tick();
        end
        check("disable_midpoll_done", k_done, 80);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (latch) late_latch++;
        end
        check("disabled_no_poll", late_latch, 0);
    endtask

    task automatic test_request_during();
        int vcnt, rises, v1, v2, r2;
        logic [7:0] b1, b2;
        logic c1, c2, lp;
        vcnt = 0; rises = 0; v1 = -1; v2 = -1; r2 = -1;
        b1 = 8'h00; b2 = 8'h00; c1 = 1'b0; c2 = 1'b1; lp = 1'b0;
        pad = 8'h24;
        poll_req = 1'b1;
        tick();
        for (int c = 1; c <= 400; c++) begin
            poll_req = (c == 20 || c == 30 || c == 40);
            if (latch && !lp) begin
                rises++;
                if (rises == 2) r2 = c;
            end
            lp = latch;
            if (buttons_valid) begin
                vcnt++;
                if (vcnt == 1) begin v1 = c; b1 = buttons; c1 = changed; end
                if (vcnt == 2) begin v2 = c; b2 = buttons; c2 = changed; end
            end
            tick();
        end
        poll_req = 1'b0;
        check("req_valid_cnt", vcnt, 2);
        check("req_poll_starts", rises, 2);
        check("req_first_done", v1, 82);
        check("req_second_latch", r2, 83);
        check("req_second_done", v2, 164);
        check("req_first_btn", b1, 8'h24);
        check("req_first_chg", c1, 1'b1);
        check("req_second_btn", b2, 8'h24);
        check("req_second_chg", c2, 1'b0);
    endtask

    task automatic test_reset_mid();
        int lat, vcnt, lcnt;
        logic [7:0] b;
        logic c;
        vcnt = 0; lcnt = 0;
        poll_once(8'hFF, lat, b, c);
        check("prereset_buttons", b, 8'hFF);
        pad = 8'h5A;
        poll_req = 1'b1;
        tick();
        poll_req = 1'b0;
        for (int k = 1; k < 40; k++) tick();
        reset = 1'b0;
        tick();
        check("rst_latch", latch, 1'b0);
        check("rst_pulse", pulse, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_buttons", buttons, 8'h00);
        reset = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (buttons_valid) vcnt++;
            if (latch) lcnt++;
            tick();
        end
        check("rst_no_valid", vcnt, 0);
        check("rst_no_restart", lcnt, 0);
        poll_once(8'h5A, lat, b, c);
        check("postrst_latency", lat, 82);
        check("postrst_buttons", b, 8'h5A);
        check("postrst_changed", c, 1'b1);
    endtask

    // Random pads and random extra requests against a timing-rule model
    task automatic test_random();
        logic [7:0] p;
        int extra_at, vcnt, t1, t2;
        logic [7:0] b1, b2;
        logic c1, c2, busy_end;
        model_btn = 8'h5A;
        for (int it = 0; it < 16; it++) begin
            p = 8'($urandom);
            extra_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 82) : -1;
            for (int g = 0; g < int'($urandom_range(0, 15)); g++) tick();
            vcnt = 0; t1 = -1; t2 = -1; b1 = 8'h00; b2 = 8'h00; c1 = 1'b0; c2 = 1'b0;
            pad = p;
            poll_req = 1'b1;
            tick();
            for (int c = 1; c <= 260; c++) begin
                poll_req = (c == extra_at);
                if (buttons_valid) begin
                    vcnt++;
                    if (vcnt == 1) begin t1 = c; b1 = buttons; c1 = changed; end
                    if (vcnt == 2) begin t2 = c; b2 = buttons; c2 = changed; end
                end
                tick();
            end
            poll_req = 1'b0;
            busy_end = busy;
            check($sformatf("rnd%0d_strobes", it), vcnt, (extra_at > 0) ? 2 : 1);
            check($sformatf("rnd%0d_t1", it), t1, 82);
            check($sformatf("rnd%0d_btn1", it), b1, p);
            check($sformatf("rnd%0d_chg1", it), c1, (p != model_btn));
            if (extra_at > 0) begin
                check($sformatf("rnd%0d_t2", it), t2, 164);
                check($sformatf("rnd%0d_btn2", it), b2, p);
                check($sformatf("rnd%0d_chg2", it), c2, 1'b0);
            end
            check($sformatf("rnd%0d_idle", it), busy_end, 1'b0);
            model_btn = p;
        end
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check("reset_latch", latch, 1'b0);
        check("reset_pulse", pulse, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", buttons_valid, 1'b0);
        check("reset_changed", changed, 1'b0);
        check("reset_buttons", buttons, 8'h00);
        reset = 1'b1;
        tick();
        test_single();
        test_table();
        test_periodic();
        test_request_during();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_poll_sequencer.md
NES_POLL_SEQUENCER -- requirements
Module: nes_poll_sequencer

Interface
REQ-001 Parameter POLL_DIV, default 15000: clock cycles between automatic polls (about 60 Hz at 900 kHz).
REQ-002 Parameter LATCH_CYC, default 11: latch high time in cycles.
REQ-003 Parameter HALF_CYC, default 5: duration in cycles of each high phase and each low phase of the controller clock.
REQ-004 clk_900KHz  in  1  sole clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 poll_en  in  1  enables periodic polling.
REQ-007 poll_req  in  1  single-cycle request for an immediate poll.
REQ-008 data  in  1  serial data from the controller, active-low (0 = pressed).
REQ-009 latch  out  1  controller latch strobe.
REQ-010 pulse  out  1  controller shift clock.
REQ-011 buttons  out  8  pressed = 1; bit order {right, left, down, up, start, select, b, a}, so a = bit0.
REQ-012 buttons_valid  out  1  one-cycle strobe: buttons updated.
REQ-013 changed  out  1  one-cycle strobe, coincident with buttons_valid, when the new buttons differ from the old value.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, LATCH, CLK_HI, CLK_LO, DONE.
REQ-016 Poll timer counts 0..POLL_DIV-1 and wraps to 0; it runs only while poll_en = 1 and holds at 0 while poll_en = 0.
REQ-017 A poll is triggered by the timer wrap or by poll_req.
- IDLE with a trigger -> LATCH on the next cycle.
- A trigger while busy sets a single pending flag.
- DONE with the pending flag set -> LATCH directly, and the flag clears.
- Multiple triggers while busy collapse into one pending poll.
REQ-018 LATCH: latch = 1 for exactly LATCH_CYC cycles; data is sampled into shift bit0 in the last LATCH cycle; then -> CLK_HI.
REQ-019 CLK_HI: pulse = 1 for HALF_CYC cycles, then -> CLK_LO.
REQ-020 CLK_LO: pulse = 0 for HALF_CYC cycles.
- In the last cycle of CLK_LO, ~data is sampled into shift bit[bit_cnt].
- bit_cnt (3 bits) runs 1..7.
- If bit_cnt = 7 -> DONE; otherwise bit_cnt increments and the FSM goes to CLK_HI.
REQ-021 Exactly 7 pulse high phases occur per poll; latch and pulse are never high in the same cycle.
REQ-022 DONE lasts one cycle.
- buttons <= shift register.
- buttons_valid = 1.
- changed = (shift != old buttons).
- Then -> IDLE, or -> LATCH if a poll is pending.
REQ-023 Latency with defaults: the DONE cycle is 82 cycles after the trigger cycle (trigger at cycle 0, LATCH at cycles 1-11, last sample at cycle 81).
REQ-024 buttons is stable between DONE cycles; partial shift data is never visible on buttons.
REQ-025 Deasserting poll_en mid-poll does not abort the poll in progress.
REQ-026 The phase counter width is sized by $clog2 of max(LATCH_CYC, HALF_CYC, POLL_DIV); all counts are unsigned and wrap only as specified.

Reset
REQ-027 While reset = 0 at a clock edge, the following are cleared: state = IDLE; latch, pulse, buttons_valid, changed, busy = 0; buttons = 8'h00; shift, bit_cnt, phase counter, poll timer and pending flag = 0.
REQ-028 Reset asserted mid-poll abandons the poll with no buttons_valid strobe; the first poll after release starts only on a new trigger.

Structure
REQ-029 Shared package nes_pkg contains:
- state enum nes_state_t;
- button index constants BTN_A = 0 .. BTN_RIGHT = 7;
- default timing constants NES_POLL_DIV, NES_LATCH_CYC, NES_HALF_CYC.
REQ-030 One sub-module nes_poll_timer (poll-rate counter with enable and wrap strobe); the FSM, shift register and phase counter stay in nes_poll_sequencer.

Verification
REQ-031 Single poll:
- Stimulus: poll_req at cycle 0; controller model drives the pattern a = pressed, start = pressed, all other buttons released.
- Required: latch high for cycles 1-11; 7 pulse highs of 5 cycles each; buttons = 8'h09 with buttons_valid and changed at cycle 82; busy low at cycle 83.
REQ-032 Periodic polling:
- Stimulus: POLL_DIV = 200, poll_en = 1, constant data = 1.
- Required: a poll starts every 200 cycles; buttons = 8'h00; changed never asserted after the first poll.
REQ-033 Request during poll:
- Stimulus: poll_req at cycle 0, then three poll_req pulses at cycles 20-40.
- Required: exactly one extra poll; latch rises in the cycle after the first DONE (cycle 83); exactly two buttons_valid strobes.
REQ-034 Reset mid-poll:
- Stimulus: reset = 0 at cycle 40 of a poll.
- Required: next cycle shows latch = pulse = busy = 0 and buttons = 8'h00; no buttons_valid strobe until a new trigger.
REQ-035 Change detection:
- Stimulus: two polls; first with right pressed (8'h80), second with up pressed (8'h10).
- Required: changed = 1 on both DONE cycles; a third poll with 8'h10 again gives changed = 0.
